// File: rtl/shipgunner_grid_pkg.sv
// Shared state encoding and elaboration-time width helpers for the battleship grid.
package shipgunner_grid_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_OVER  = 2'd2
   } state_e;

   localparam int MAX_CELLS = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int popcount(input logic [MAX_CELLS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_CELLS; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/shipgunner_grid_if.sv
// Board-side bundle: switches/buttons in, LED and display data out.
interface shipgunner_grid_if
   import shipgunner_grid_pkg::*;
#(
   parameter int ROWS = 3,
   parameter int COLS = 3
);
   localparam int CELLS = ROWS * COLS;
   localparam int RW    = clog2(ROWS);
   localparam int CW    = clog2(COLS);
   localparam int NW    = clog2(CELLS + 1);

   logic             CH0;
   logic             NBT0;
   logic [RW-1:0]    ROWSEL;
   logic [CW-1:0]    COLSEL;
   logic [CELLS-1:0] SHIPMAP;
   logic             OUT;
   logic             GLED;
   logic             RLED;
   logic             YLED;
   logic [CELLS-1:0] SHOTMAP;
   logic [NW-1:0]    HITS;
   logic [NW-1:0]    SHOTS_LEFT;
   logic             WIN;
   logic             LOSE;
   logic [1:0]       STATE;

   modport master (
      output CH0, NBT0, ROWSEL, COLSEL, SHIPMAP,
      input  OUT, GLED, RLED, YLED, SHOTMAP, HITS, SHOTS_LEFT, WIN, LOSE, STATE
   );

   modport slave (
      input  CH0, NBT0, ROWSEL, COLSEL, SHIPMAP,
      output OUT, GLED, RLED, YLED, SHOTMAP, HITS, SHOTS_LEFT, WIN, LOSE, STATE
   );

endinterface

// File: rtl/shipgunner_grid_button_edge_sync.sv
// Synchroniser for an active-low asynchronous button plus falling-edge strobe.
module button_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic fire_evt
);
   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_pipe <= '0;
         prev      <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], btn_n};
         prev      <= sync_pipe[SYNC_STAGES-1];
      end
   end

   // Reset leaves prev=0, so a button already held at reset release never fires.
   assign fire_evt = prev & ~sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/shipgunner_grid.sv
// Full-board battleship gunner: resolves shots against a captured ship map,
// tracks ammo/hits and declares win or lose.
module shipgunner_grid
   import shipgunner_grid_pkg::*;
#(
   parameter int ROWS = 3,
   parameter int COLS = 3,
   parameter int AMMO = 5
) (
   input  logic             CLK,
   input  logic             NRST,
   shipgunner_grid_if.slave bus
);
   localparam int CELLS = ROWS * COLS;
   localparam int NW    = clog2(CELLS + 1);

   logic             fire_evt;
   state_e           state;
   logic [CELLS-1:0] ship_q;
   logic [CELLS-1:0] shot_q;
   logic [NW-1:0]    target;
   logic [NW-1:0]    hits;
   logic [NW-1:0]    left;
   logic             out_q, gled, rled, yled, win, lose;

   logic             in_range, cell_ship, cell_shot;
   logic [CELLS-1:0] cell_mask;

   button_edge_sync #(.SYNC_STAGES(2)) u_fire (
      .clk      (CLK),
      .rst_n    (NRST),
      .btn_n    (bus.NBT0),
      .fire_evt (fire_evt)
   );

   // One-hot cell select; stays empty for out-of-board coordinates.
   always_comb begin
      in_range  = (int'(bus.ROWSEL) < ROWS) && (int'(bus.COLSEL) < COLS);
      cell_mask = '0;
      if (in_range)
         cell_mask = CELLS'(1) << (int'(bus.ROWSEL) * COLS + int'(bus.COLSEL));
      cell_ship = |(cell_mask & ship_q);
      cell_shot = |(cell_mask & shot_q);
   end

   always_ff @(posedge CLK) begin
      if (!NRST || !bus.CH0) begin
         state  <= ST_IDLE;
         ship_q <= '0;
         shot_q <= '0;
         target <= '0;
         hits   <= '0;
         left   <= '0;
         out_q  <= 1'b0;
         gled   <= 1'b0;
         rled   <= 1'b0;
         yled   <= 1'b0;
         win    <= 1'b0;
         lose   <= 1'b0;
      end else begin
         out_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               state  <= ST_ARMED;
               ship_q <= bus.SHIPMAP;
               target <= NW'(popcount(MAX_CELLS'(bus.SHIPMAP)));
               left   <= NW'(AMMO);
            end
            ST_ARMED: begin
               // End-of-game check takes precedence, so a shot never lands with zero ammo.
               if (hits == target) begin
                  win   <= 1'b1;
                  state <= ST_OVER;
               end else if (left == '0) begin
                  lose  <= 1'b1;
                  state <= ST_OVER;
               end else if (fire_evt) begin
                  if (!in_range || cell_shot) begin
                     yled <= 1'b1;
                  end else begin
                     shot_q <= shot_q | cell_mask;
                     left   <= left - NW'(1);
                     yled   <= 1'b0;
                     if (cell_ship) begin
                        hits  <= hits + NW'(1);
                        gled  <= 1'b1;
                        rled  <= 1'b0;
                        out_q <= 1'b1;
                     end else begin
                        gled <= 1'b0;
                        rled <= 1'b1;
                     end
                  end
               end
            end
            ST_OVER: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.OUT        = out_q;
   assign bus.GLED       = gled;
   assign bus.RLED       = rled;
   assign bus.YLED       = yled;
   assign bus.SHOTMAP    = shot_q;
   assign bus.HITS       = hits;
   assign bus.SHOTS_LEFT = left;
   assign bus.WIN        = win;
   assign bus.LOSE       = lose;
   assign bus.STATE      = state;

endmodule

// File: tb/tb_shipgunner_grid.sv
// Directed bench for shipgunner_grid with default 3x3 board, 5 shots, ships at cells 0,1,4.
module tb_shipgunner_grid;
   logic clk;
   logic nrst;
   int   errors;
   int   checks;
   logic [24:0] outs;

   shipgunner_grid_if #(.ROWS(3), .COLS(3)) bus ();

   shipgunner_grid #(.ROWS(3), .COLS(3), .AMMO(5)) dut (
      .CLK  (clk),
      .NRST (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign outs = {bus.OUT, bus.GLED, bus.RLED, bus.YLED, bus.SHOTMAP, bus.HITS,
                  bus.SHOTS_LEFT, bus.WIN, bus.LOSE, bus.STATE};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the button held; returns at the edge where the shot is registered.
   task automatic press(input int r, input int c);
      bus.ROWSEL = 2'(r);
      bus.COLSEL = 2'(c);
      bus.NBT0   = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic release_btn();
      bus.NBT0 = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic new_game();
      bus.CH0 = 1'b0;
      tick();
      bus.CH0 = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      bus.CH0 = 1'b0;
      bus.NBT0 = 1'b1;
      bus.ROWSEL = '0;
      bus.COLSEL = '0;
      bus.SHIPMAP = 9'b000_010_011;
      tick();
      tick();
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL reset_outs: got %h want 0", outs);
      end
      nrst = 1'b1;
      bus.CH0 = 1'b1;
      tick();
      checks++;
      if (bus.STATE !== 2'd1) begin
         errors++; $display("FAIL arm_state: got %0d want 1", bus.STATE);
      end
      checks++;
      if (bus.SHOTS_LEFT !== 4'd5) begin
         errors++; $display("FAIL arm_left: got %0d want 5", bus.SHOTS_LEFT);
      end
      checks++;
      if (bus.HITS !== 4'd0) begin
         errors++; $display("FAIL arm_hits: got %0d want 0", bus.HITS);
      end
   endtask

   task automatic test_hit_miss();
      press(0, 0);
      checks++;
      if ({bus.GLED, bus.RLED, bus.OUT} !== 3'b101) begin
         errors++; $display("FAIL hit_leds: got g/r/out=%b want 101", {bus.GLED, bus.RLED, bus.OUT});
      end
      checks++;
      if (bus.HITS !== 4'd1 || bus.SHOTS_LEFT !== 4'd4) begin
         errors++; $display("FAIL hit_counts: got hits=%0d left=%0d want 1/4", bus.HITS, bus.SHOTS_LEFT);
      end
      checks++;
      if (bus.SHOTMAP !== 9'h001) begin
         errors++; $display("FAIL hit_shotmap: got %h want 001", bus.SHOTMAP);
      end
      tick();
      checks++;
      if (bus.OUT !== 1'b0) begin
         errors++; $display("FAIL hit_pulse_len: got out=%b want 0", bus.OUT);
      end
      release_btn();
      press(2, 2);
      checks++;
      if ({bus.GLED, bus.RLED, bus.YLED} !== 3'b010) begin
         errors++; $display("FAIL miss_leds: got g/r/y=%b want 010", {bus.GLED, bus.RLED, bus.YLED});
      end
      checks++;
      if (bus.SHOTS_LEFT !== 4'd3 || bus.HITS !== 4'd1 || bus.SHOTMAP !== 9'h101) begin
         errors++; $display("FAIL miss_counts: got left=%0d hits=%0d map=%h want 3/1/101",
                            bus.SHOTS_LEFT, bus.HITS, bus.SHOTMAP);
      end
      release_btn();
   endtask

   task automatic test_rejects();
      press(0, 0);
      checks++;
      if ({bus.GLED, bus.RLED, bus.YLED} !== 3'b011) begin
         errors++; $display("FAIL rej_dup_leds: got g/r/y=%b want 011", {bus.GLED, bus.RLED, bus.YLED});
      end
      checks++;
      if (bus.SHOTS_LEFT !== 4'd3 || bus.HITS !== 4'd1 || bus.SHOTMAP !== 9'h101) begin
         errors++; $display("FAIL rej_dup_counts: got left=%0d hits=%0d map=%h want 3/1/101",
                            bus.SHOTS_LEFT, bus.HITS, bus.SHOTMAP);
      end
      release_btn();
      press(3, 1);
      checks++;
      if (bus.YLED !== 1'b1 || bus.SHOTMAP !== 9'h101 || bus.SHOTS_LEFT !== 4'd3) begin
         errors++; $display("FAIL rej_range: got y=%b map=%h left=%0d want 1/101/3",
                            bus.YLED, bus.SHOTMAP, bus.SHOTS_LEFT);
      end
      release_btn();
      // Cell 6 is a miss; a second firing would reject and raise YLED.
      press(2, 0);
      for (int i = 0; i < 17; i++) tick();
      checks++;
      if (bus.SHOTS_LEFT !== 4'd2 || bus.SHOTMAP !== 9'h141) begin
         errors++; $display("FAIL hold_once_counts: got left=%0d map=%h want 2/141", bus.SHOTS_LEFT, bus.SHOTMAP);
      end
      checks++;
      if ({bus.RLED, bus.YLED} !== 2'b10) begin
         errors++; $display("FAIL hold_once_leds: got r/y=%b want 10", {bus.RLED, bus.YLED});
      end
      release_btn();
   endtask

   task automatic test_win();
      new_game();
      checks++;
      if (bus.SHOTS_LEFT !== 4'd5 || bus.SHOTMAP !== 9'h000 || bus.STATE !== 2'd1) begin
         errors++; $display("FAIL win_fresh: got left=%0d map=%h st=%0d want 5/000/1",
                            bus.SHOTS_LEFT, bus.SHOTMAP, bus.STATE);
      end
      press(2, 2); release_btn();
      press(2, 1); release_btn();
      press(0, 0); release_btn();
      press(0, 1); release_btn();
      press(1, 1);
      checks++;
      if (bus.SHOTS_LEFT !== 4'd0 || bus.HITS !== 4'd3 || bus.OUT !== 1'b1 || bus.WIN !== 1'b0) begin
         errors++; $display("FAIL win_last_shot: got left=%0d hits=%0d out=%b win=%b want 0/3/1/0",
                            bus.SHOTS_LEFT, bus.HITS, bus.OUT, bus.WIN);
      end
      tick();
      checks++;
      if ({bus.WIN, bus.LOSE, bus.STATE} !== 4'b1010) begin
         errors++; $display("FAIL win_flags: got win/lose/st=%b want 1010", {bus.WIN, bus.LOSE, bus.STATE});
      end
      release_btn();
      press(2, 0);
      checks++;
      if (bus.SHOTMAP !== 9'h193 || bus.SHOTS_LEFT !== 4'd0 || bus.HITS !== 4'd3 || bus.YLED !== 1'b0) begin
         errors++; $display("FAIL over_ignore: got map=%h left=%0d hits=%0d y=%b want 193/0/3/0",
                            bus.SHOTMAP, bus.SHOTS_LEFT, bus.HITS, bus.YLED);
      end
      checks++;
      if ({bus.WIN, bus.STATE, bus.GLED} !== 4'b1101) begin
         errors++; $display("FAIL over_hold: got win/st/g=%b want 1101", {bus.WIN, bus.STATE, bus.GLED});
      end
      release_btn();
   endtask

   task automatic test_lose();
      new_game();
      press(2, 2); release_btn();
      press(2, 1); release_btn();
      press(2, 0); release_btn();
      press(1, 0); release_btn();
      press(1, 2);
      checks++;
      if (bus.SHOTS_LEFT !== 4'd0 || bus.RLED !== 1'b1 || bus.LOSE !== 1'b0) begin
         errors++; $display("FAIL lose_last_shot: got left=%0d r=%b lose=%b want 0/1/0",
                            bus.SHOTS_LEFT, bus.RLED, bus.LOSE);
      end
      tick();
      checks++;
      if ({bus.LOSE, bus.WIN, bus.STATE} !== 4'b1010 || bus.HITS !== 4'd0) begin
         errors++; $display("FAIL lose_flags: got lose/win/st=%b hits=%0d want 1010/0",
                            {bus.LOSE, bus.WIN, bus.STATE}, bus.HITS);
      end
      checks++;
      if (bus.SHOTMAP !== 9'h1E8) begin
         errors++; $display("FAIL lose_shotmap: got %h want 1e8", bus.SHOTMAP);
      end
      release_btn();
      bus.CH0 = 1'b0;
      tick();
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL clear_outs: got %h want 0", outs);
      end
      bus.CH0 = 1'b1;
      tick();
      checks++;
      if (bus.SHOTS_LEFT !== 4'd5 || bus.STATE !== 2'd1) begin
         errors++; $display("FAIL rearm: got left=%0d st=%0d want 5/1", bus.SHOTS_LEFT, bus.STATE);
      end
   endtask

   task automatic test_reset_mid();
      press(0, 0); release_btn();
      press(0, 1); release_btn();
      checks++;
      if (bus.HITS !== 4'd2 || bus.STATE !== 2'd1) begin
         errors++; $display("FAIL mid_setup: got hits=%0d st=%0d want 2/1", bus.HITS, bus.STATE);
      end
      nrst = 1'b0;
      bus.NBT0 = 1'b0;
      tick();
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL mid_reset_outs: got %h want 0", outs);
      end
      bus.NBT0 = 1'b1;
      tick();
      bus.NBT0 = 1'b0;
      tick();
      checks++;
      if (outs !== 25'd0) begin
         errors++; $display("FAIL mid_reset_hold: got %h want 0", outs);
      end
      nrst = 1'b1;
      bus.NBT0 = 1'b1;
      tick();
      checks++;
      if (bus.STATE !== 2'd1 || bus.SHOTS_LEFT !== 4'd5 || bus.HITS !== 4'd0) begin
         errors++; $display("FAIL post_reset_arm: got st=%0d left=%0d hits=%0d want 1/5/0",
                            bus.STATE, bus.SHOTS_LEFT, bus.HITS);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_hit_miss();
      test_rejects();
      test_win();
      test_lose();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
